// File: rtl/fp_sqrt_iter_pkg.sv
// Shared types for the iterative square-root core: FSM encodings and a sizing helper.
package fp_sqrt_iter_pkg;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_CALC = 2'd1,
    SQ_FIN  = 2'd2
  } sq_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/fp_sqrt_step.sv
// One restoring square-root digit step: appends two radicand bits to the partial
// remainder, trial-subtracts {root,01} and keeps the result only when non-negative.
module fp_sqrt_step
  import fp_sqrt_iter_pkg::*;
#(
  parameter int W = 26
) (
  input  logic [W+1:0] rem,
  input  logic [W-1:0] root,
  input  logic [1:0]   bits,
  output logic [W+1:0] rem_next,
  output logic         root_bit
);

  logic [W+3:0] shifted;
  logic [W+3:0] trial;
  logic         neg;
  logic         unused_top;

  // rem < 2^(W+1) always, so W+4 bits hold the trial difference with a valid sign bit
  assign shifted  = {rem, bits};
  assign trial    = shifted - {2'b00, root, 2'b01};
  assign neg      = trial[W+3];
  assign rem_next = neg ? shifted[W+1:0] : trial[W+1:0];
  assign root_bit = ~neg;

  assign unused_top = ^{shifted[W+3:W+2], trial[W+2]};

endmodule

// File: rtl/fp_sqrt_iter.sv
// Iterative restoring integer square root with start/busy/done handshake.
// Define FP_SQRT_RADIX4_EN to resolve two root bits per clock instead of one.
module fp_sqrt_iter
  import fp_sqrt_iter_pkg::*;
#(
  parameter int M  = 22,
  parameter int IW = M + 4,
  parameter int OW = M + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] in,
  output logic [OW-1:0] out,
  output logic          sticky,
  output logic          busy,
  output logic          done
);

`ifdef FP_SQRT_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  // An odd OW in radix-4 gains one leading zero root bit, which leaves the result unchanged
  localparam int CYC  = ceil_div(OW, STEPS);
  localparam int OWE  = CYC * STEPS;
  localparam int RW   = 2 * OWE;
  localparam int PADB = 2 * OW - IW;
  localparam int RMW  = OWE + 2;
  localparam int CW   = $clog2(OW + 1);

  sq_state_t      state_reg, state_next;
  logic [RW-1:0]  rad_reg;
  logic [RMW-1:0] rem_reg;
  logic [OWE-1:0] root_reg;
  logic [CW-1:0]  cnt_reg;

  logic [RMW-1:0] rem_a, rem_b;
  logic [OWE-1:0] root_a, root_b;
  logic [RW-1:0]  rad_a, rad_b;
  logic           bit_a;
  logic           unused_root;

  fp_sqrt_step #(.W(OWE)) u_step0 (
    .rem      (rem_reg),
    .root     (root_reg),
    .bits     (rad_reg[RW-1 -: 2]),
    .rem_next (rem_a),
    .root_bit (bit_a)
  );

  assign root_a = {root_reg[OWE-2:0], bit_a};
  assign rad_a  = rad_reg << 2;

`ifdef FP_SQRT_RADIX4_EN
  logic bit_b;

  fp_sqrt_step #(.W(OWE)) u_step1 (
    .rem      (rem_a),
    .root     (root_a),
    .bits     (rad_a[RW-1 -: 2]),
    .rem_next (rem_b),
    .root_bit (bit_b)
  );

  assign root_b = {root_a[OWE-2:0], bit_b};
  assign rad_b  = rad_a << 2;
`else
  assign rem_b  = rem_a;
  assign root_b = root_a;
  assign rad_b  = rad_a;
`endif

  assign unused_root = ^root_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SQ_IDLE: if (start) state_next = SQ_CALC;
      SQ_CALC: if (cnt_reg == '0) state_next = SQ_FIN;
      SQ_FIN:  state_next = SQ_IDLE;
      default: state_next = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= SQ_IDLE;
      rad_reg   <= '0;
      rem_reg   <= '0;
      root_reg  <= '0;
      cnt_reg   <= '0;
      out       <= '0;
      sticky    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;
      case (state_reg)
        SQ_IDLE: begin
          if (start) begin
            // Radicand is scaled by 2^(2*OW-IW) so the root comes out OW bits wide
            rad_reg  <= RW'(in) << PADB;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= CW'(CYC - 1);
            busy     <= 1'b1;
          end
        end
        SQ_CALC: begin
          rad_reg  <= rad_b;
          rem_reg  <= rem_b;
          root_reg <= root_b;
          cnt_reg  <= cnt_reg - CW'(1);
        end
        SQ_FIN: begin
          out    <= root_reg[OW-1:0];
          sticky <= |rem_reg;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed bench for fp_sqrt_iter: known roots, latency, busy/done handshake,
// start hammering while busy and asynchronous abort. Honours FP_SQRT_RADIX4_EN.
module tb_fp_sqrt_iter;

`ifdef FP_SQRT_RADIX4_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 27;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [25:0] in_v = '0;
  logic [25:0] out_v;
  logic        sticky;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  fp_sqrt_iter dut (
    .clk    (clk),
    .rst    (rst_n),
    .start  (start),
    .in     (in_v),
    .out    (out_v),
    .sticky (sticky),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Launch one operation and follow it to done; hammer keeps start high with a new operand
  task automatic run_op(input logic [25:0] val, input logic [25:0] eout, input logic es,
                        input bit hammer);
    int cyc;
    int busy_low;
    bit seen;
    @(negedge clk);
    in_v  = val;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hammer) in_v = 26'd4;
    else start = 1'b0;
    cyc = 0;
    busy_low = 0;
    seen = 0;
    while (cyc < 60 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1;
      else if (!busy) busy_low++;
    end
    start = 1'b0;
    check("latency", 64'(cyc), 64'(LAT));
    check("busy_gap", 64'(busy_low), 64'd0);
    check("busy_at_done", 64'(busy), 64'd0);
    check("out", 64'(out_v), 64'(eout));
    check("sticky", 64'(sticky), 64'(es));
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);
    check("out_hold", 64'(out_v), 64'(eout));
    $display("op in=%0d out=%0d sticky=%0d latency=%0d hammer=%0d", val, out_v, sticky, cyc, hammer);
  endtask

  task automatic quiet(input string tag, input int n);
    int dones;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check(tag, 64'(dones), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 64'(out_v), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(26'd1,        26'd8192,     1'b0, 1'b0);
    run_op(26'd2,        26'd11585,    1'b1, 1'b0);
    run_op(26'd0,        26'd0,        1'b0, 1'b0);
    run_op(26'd3,        26'd14188,    1'b1, 1'b0);
    run_op(26'd8388608,  26'd23726566, 1'b1, 1'b0);
    run_op(26'd16777216, 26'd33554432, 1'b0, 1'b0);
    run_op(26'd33554432, 26'd47453132, 1'b1, 1'b0);
    run_op(26'h3FFFFFF,  26'h3FFFFFF,  1'b1, 1'b0);

    // start asserted every cycle while busy: only the first operand is computed
    run_op(26'd1, 26'd8192, 1'b0, 1'b1);
    quiet("hammer_extra_done", 40);

    // back-to-back: start in the first IDLE cycle after done
    run_op(26'd4, 26'd16384, 1'b0, 1'b0);
    run_op(26'd1, 26'd8192,  1'b0, 1'b0);

    // asynchronous abort part-way through a computation
    @(negedge clk);
    in_v  = 26'd16777216;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out", 64'(out_v), 64'd0);
    check("abort_sticky", 64'(sticky), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    $display("abort out=%0d sticky=%0d busy=%0d done=%0d", out_v, sticky, busy, done);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("abort_no_done", 40);
    run_op(26'd2, 26'd11585, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
